// File: rtl/rgb_to_gray_avalon_st_if.sv
// Avalon-ST sink/source pair plus the status conduit of the RGB-to-gray stage.
// slave = the converter's view, master = the view of whatever drives and observes it.
interface rgb_to_gray_avalon_st_if;
  logic [23:0] asi_sink1_data;
  logic        asi_sink1_startofpacket;
  logic        asi_sink1_endofpacket;
  logic        asi_sink1_valid;
  logic        asi_sink1_ready;
  logic        aso_source1_ready;
  logic [7:0]  aso_source1_data;
  logic        aso_source1_startofpacket;
  logic        aso_source1_endofpacket;
  logic        aso_source1_valid;
  logic        coe_status_clear;
  logic        coe_status_framing_error;
  logic [15:0] coe_status_frame_count;

  modport slave (
    input  asi_sink1_data, asi_sink1_startofpacket, asi_sink1_endofpacket, asi_sink1_valid,
    output asi_sink1_ready,
    input  aso_source1_ready,
    output aso_source1_data, aso_source1_startofpacket, aso_source1_endofpacket, aso_source1_valid,
    input  coe_status_clear,
    output coe_status_framing_error, coe_status_frame_count
  );

  modport master (
    output asi_sink1_data, asi_sink1_startofpacket, asi_sink1_endofpacket, asi_sink1_valid,
    input  asi_sink1_ready,
    output aso_source1_ready,
    input  aso_source1_data, aso_source1_startofpacket, aso_source1_endofpacket, aso_source1_valid,
    output coe_status_clear,
    input  coe_status_framing_error, coe_status_frame_count
  );
endinterface

// File: rtl/rgb_to_gray_avalon_st.sv
// RGB888 -> 8-bit luma converter that re-frames the stream into packets of exactly
// IMG_X_SIZE*IMG_Y_SIZE pixels, with a sticky framing-error flag and a frame counter.
module rgb_to_gray_avalon_st #(
  parameter int IMG_X_SIZE = 320,
  parameter int IMG_Y_SIZE = 240
) (
  input  logic                   csi_clkrst_clk,
  input  logic                   csi_clkrst_reset_n,
  rgb_to_gray_avalon_st_if.slave st
);
  localparam int N  = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [0:0] WAIT_SOP = 1'b0;
  localparam logic [0:0] IN_PKT   = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_sop_q, s1_sop_d;
  logic            s1_eop_q, s1_eop_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;
  logic [7:0]      gray_q, gray_d;
  logic            err_q, err_d;
  logic [15:0]     fc_q, fc_d;

  logic            advance;
  logic            accept;
  logic            fwd;
  logic            fwd_sop;
  logic            fwd_eop;
  logic            new_err;
  logic            frame_done;
  logic [15:0]     sum;
  logic [2:0][15:0] prod_vec;

  // One global enable: the whole pipe moves only when the output slot can be refilled.
  assign advance = ~out_valid_q | st.aso_source1_ready;
  assign accept  = st.asi_sink1_valid & advance;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fwd     = 1'b0;
    fwd_sop = 1'b0;
    fwd_eop = 1'b0;
    new_err = 1'b0;
    if (accept) begin
      case (state_q)
        WAIT_SOP: begin
          if (st.asi_sink1_startofpacket) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            cnt_d   = CW'(1);
            state_d = IN_PKT;
          end else begin
            new_err = 1'b1;
          end
        end
        default: begin
          fwd     = 1'b1;
          new_err = st.asi_sink1_startofpacket;
          if (cnt_q == LAST_IDX) begin
            // Length wins over the source's framing: close the packet regardless.
            fwd_eop = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_SOP;
            if (!st.asi_sink1_endofpacket) new_err = 1'b1;
          end else if (st.asi_sink1_endofpacket) begin
            fwd_eop = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_SOP;
            new_err = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Channel gi: 0=B, 1=G, 2=R, each weighted by its BT.601 coefficient scaled by 256.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      localparam logic [15:0] COEF = (gi == 2) ? 16'd77 : (gi == 1) ? 16'd150 : 16'd29;
      logic [15:0] prod_q, prod_d;

      assign prod_d       = advance ? 16'(st.asi_sink1_data[gi*8 +: 8]) * COEF : prod_q;
      assign prod_vec[gi] = prod_q;

      always_ff @(posedge csi_clkrst_clk or negedge csi_clkrst_reset_n) begin
        if (!csi_clkrst_reset_n) prod_q <= '0;
        else                     prod_q <= prod_d;
      end
    end
  endgenerate

  assign sum = prod_vec[0] + prod_vec[1] + prod_vec[2] + 16'd128;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sop_d    = s1_sop_q;
    s1_eop_d    = s1_eop_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    gray_d      = gray_q;
    if (advance) begin
      s1_valid_d  = fwd;
      s1_sop_d    = fwd_sop;
      s1_eop_d    = fwd_eop;
      out_valid_d = s1_valid_q;
      out_sop_d   = s1_sop_q;
      out_eop_d   = s1_eop_q;
      gray_d      = sum[15:8];
    end
  end

  assign frame_done = out_valid_q & out_eop_q & st.aso_source1_ready;

  // A new error outranks a simultaneous clear; a clear outranks a completing frame.
  always_comb begin
    err_d = (st.coe_status_clear ? 1'b0 : err_q) | new_err;
    fc_d  = st.coe_status_clear ? 16'd0 : fc_q + {15'd0, frame_done};
  end

  always_ff @(posedge csi_clkrst_clk or negedge csi_clkrst_reset_n) begin
    if (!csi_clkrst_reset_n) begin
      state_q     <= WAIT_SOP;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      gray_q      <= '0;
      err_q       <= 1'b0;
      fc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      gray_q      <= gray_d;
      err_q       <= err_d;
      fc_q        <= fc_d;
    end
  end

  assign st.asi_sink1_ready           = advance;
  assign st.aso_source1_valid         = out_valid_q;
  assign st.aso_source1_data          = gray_q;
  assign st.aso_source1_startofpacket = out_sop_q;
  assign st.aso_source1_endofpacket   = out_eop_q;
  assign st.coe_status_framing_error  = err_q;
  assign st.coe_status_frame_count    = fc_q;
endmodule

// File: tb/tb_rgb_to_gray_avalon_st.sv
// Directed bench for rgb_to_gray_avalon_st on a 4x2 image: a table of pixels with
// hand-computed luma, replayed under clean, stalled, short, long, junk and reset scenarios.
module tb_rgb_to_gray_avalon_st;
  localparam int X = 4;
  localparam int Y = 2;
  localparam int N = X * Y;

  typedef struct {
    logic [23:0] rgb;
    logic        sop;
    logic        eop;
    logic [7:0]  gray;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic toggle_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  vec_t  frame [N];
  beat_t out_q[$];
  int    out_cyc[$];
  int    acc_cyc[$];

  rgb_to_gray_avalon_st_if bus();

  rgb_to_gray_avalon_st #(
    .IMG_X_SIZE(X),
    .IMG_Y_SIZE(Y)
  ) dut (
    .csi_clkrst_clk    (clk),
    .csi_clkrst_reset_n(rst_n),
    .st                (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Downstream ready: constant 1, or 1010... when toggle_en is set.
  initial begin
    bus.aso_source1_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.aso_source1_ready = toggle_en ? ~bus.aso_source1_ready : 1'b1;
    end
  end

  // Source monitor: records transfers and checks outputs stay put across a stall.
  initial begin
    logic  hold_pending;
    beat_t held;
    beat_t b;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (bus.asi_sink1_valid && bus.asi_sink1_ready) acc_cyc.push_back(cyc);
        if (hold_pending) begin
          checks++;
          if (!bus.aso_source1_valid || bus.aso_source1_data !== held.d ||
              bus.aso_source1_startofpacket !== held.sop || bus.aso_source1_endofpacket !== held.eop) begin
            failures++;
            $display("FAIL hold_while_stalled actual=v%0b/%0h required=v1/%0h",
                     bus.aso_source1_valid, bus.aso_source1_data, held.d);
          end
        end
        b.d   = bus.aso_source1_data;
        b.sop = bus.aso_source1_startofpacket;
        b.eop = bus.aso_source1_endofpacket;
        hold_pending = bus.aso_source1_valid && !bus.aso_source1_ready;
        held = b;
        if (bus.aso_source1_valid && bus.aso_source1_ready) begin
          out_q.push_back(b);
          out_cyc.push_back(cyc);
        end
      end else begin
        hold_pending = 1'b0;
      end
      cyc++;
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    bus.asi_sink1_data          = d;
    bus.asi_sink1_startofpacket = s;
    bus.asi_sink1_endofpacket   = e;
    bus.asi_sink1_valid         = 1'b1;
    while (!bus.asi_sink1_ready && n < 50) begin
      chk("sink_ready_follows_stall", {31'd0, bus.asi_sink1_ready},
          {31'd0, ~bus.aso_source1_valid | bus.aso_source1_ready});
      @(negedge clk);
      n++;
    end
    if (!bus.asi_sink1_ready) chk("sink_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.asi_sink1_valid         = 1'b0;
    bus.asi_sink1_startofpacket = 1'b0;
    bus.asi_sink1_endofpacket   = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int eop_at);
    for (int i = 0; i < nbeats; i++)
      send_beat(frame[i % N].rgb, i == 0, i == eop_at - 1);
    idle();
  endtask

  task automatic wait_outs(input int n);
    int b;
    b = 0;
    while (out_q.size() < n && b < 300) begin
      @(posedge clk);
      b++;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("output_beat_count", out_q.size(), n);
  endtask

  task automatic check_frame(input int n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      chk($sformatf("gray[%0d]", i), {24'd0, out_q[i].d}, {24'd0, frame[i].gray});
      chk($sformatf("sop[%0d]", i), {31'd0, out_q[i].sop}, {31'd0, i == 0});
      chk($sformatf("eop[%0d]", i), {31'd0, out_q[i].eop}, {31'd0, i == n - 1});
    end
    out_q.delete();
  endtask

  task automatic check_status(input string tag, input logic err, input logic [15:0] fc);
    @(negedge clk);
    chk({tag, "_error"}, {31'd0, bus.coe_status_framing_error}, {31'd0, err});
    chk({tag, "_frame_count"}, {16'd0, bus.coe_status_frame_count}, {16'd0, fc});
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.coe_status_clear = 1'b1;
    @(negedge clk);
    bus.coe_status_clear = 1'b0;
  endtask

  initial begin
    int lat;
    frame[0] = '{24'hFFFFFF, 1'b1, 1'b0, 8'hFF};
    frame[1] = '{24'hFF0000, 1'b0, 1'b0, 8'h4D};
    frame[2] = '{24'h00FF00, 1'b0, 1'b0, 8'h95};
    frame[3] = '{24'h0000FF, 1'b0, 1'b0, 8'h1D};
    frame[4] = '{24'h000000, 1'b0, 1'b0, 8'h00};
    frame[5] = '{24'h808080, 1'b0, 1'b0, 8'h80};
    frame[6] = '{24'h808080, 1'b0, 1'b0, 8'h80};
    frame[7] = '{24'h808080, 1'b0, 1'b1, 8'h80};

    bus.asi_sink1_data          = '0;
    bus.asi_sink1_startofpacket = 1'b0;
    bus.asi_sink1_endofpacket   = 1'b0;
    bus.asi_sink1_valid         = 1'b0;
    bus.coe_status_clear        = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, bus.aso_source1_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.aso_source1_data}, 32'd0);
    chk("rst_sop", {31'd0, bus.aso_source1_startofpacket}, 32'd0);
    chk("rst_eop", {31'd0, bus.aso_source1_endofpacket}, 32'd0);
    rst_n = 1'b1;
    check_status("rst", 1'b0, 16'd0);
    chk("rst_sink_ready", {31'd0, bus.asi_sink1_ready}, 32'd1);

    // Clean frame, downstream always ready
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < N; i++) send_beat(frame[i].rgb, frame[i].sop, frame[i].eop);
    idle();
    wait_outs(N);
    lat = (acc_cyc.size() > 0 && out_cyc.size() > 0) ? out_cyc[0] - acc_cyc[0] : -1;
    chk("first_output_latency", lat, 2);
    check_frame(N);
    check_status("clean", 1'b0, 16'd1);

    // Same frame under 1010 backpressure
    toggle_en = 1'b1;
    for (int i = 0; i < N; i++) send_beat(frame[i].rgb, frame[i].sop, frame[i].eop);
    idle();
    wait_outs(N);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    check_frame(N);
    check_status("stall", 1'b0, 16'd2);
    pulse_clear();
    check_status("clear1", 1'b0, 16'd0);

    // Short frame: EOP on pixel 5, then a normal frame
    send_frame(5, 5);
    wait_outs(5);
    check_frame(5);
    check_status("short", 1'b1, 16'd1);
    send_frame(N, N);
    wait_outs(N);
    check_frame(N);
    check_status("after_short", 1'b1, 16'd2);
    pulse_clear();

    // Three beats without SOP; the first coincides with a clear, which must lose
    @(negedge clk);
    bus.coe_status_clear = 1'b1;
    send_beat(24'h123456, 1'b0, 1'b0);
    @(negedge clk);
    bus.coe_status_clear = 1'b0;
    bus.asi_sink1_valid  = 1'b0;
    chk("clear_vs_error", {31'd0, bus.coe_status_framing_error}, 32'd1);
    send_beat(24'h654321, 1'b0, 1'b0);
    send_beat(24'hABCDEF, 1'b0, 1'b1);
    send_frame(N, N);
    wait_outs(N);
    check_frame(N);
    check_status("junk", 1'b1, 16'd1);
    pulse_clear();

    // 10-beat frame with EOP only on beat 10
    send_frame(10, 10);
    wait_outs(N);
    check_frame(N);
    check_status("long", 1'b1, 16'd1);
    pulse_clear();
    check_status("clear2", 1'b0, 16'd0);

    // Asynchronous reset after pixel 3
    for (int i = 0; i < 3; i++) send_beat(frame[i].rgb, frame[i].sop, frame[i].eop);
    @(negedge clk);
    bus.asi_sink1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.aso_source1_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    send_beat(frame[3].rgb, 1'b0, 1'b0);
    send_beat(frame[4].rgb, 1'b0, 1'b0);
    send_frame(N, N);
    wait_outs(N);
    check_frame(N);
    check_status("post_reset", 1'b1, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rgb_to_gray_avalon_st.md
# rgb_to_gray_avalon_st

Avalon-ST pixel-stream stage that converts 24-bit RGB pixels into 8-bit luminance and re-frames them into clean packets of exactly IMG_X_SIZE*IMG_Y_SIZE pixels. It sits directly upstream of the Sobel streaming wrapper and drives its 8-bit sink, with SOP/EOP regenerated. Packets are well formed even when the camera/DMA source is sloppy. The conversion is a fully pipelined two-stage datapath with full backpressure support. Framing violations are reported through a sticky status conduit.

## Interface
Parameters:
- IMG_X_SIZE, 320, pixels per line.
- IMG_Y_SIZE, 240, lines per frame. N = IMG_X_SIZE*IMG_Y_SIZE; N ≥ 2 required.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - csi_clkrst_clk, in, 1, the clock.
  - csi_clkrst_reset_n, in, 1, the reset.
- asi_sink1_data, in, 24, RGB pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- asi_sink1_startofpacket, in, 1, first pixel of frame.
- asi_sink1_endofpacket, in, 1, last pixel of frame.
- asi_sink1_valid, in, 1, beat valid.
- asi_sink1_ready, out, 1, sink ready (readyLatency 0).
- aso_source1_ready, in, 1, downstream ready (readyLatency 0).
- aso_source1_data, out, 8, gray pixel.
- aso_source1_startofpacket, out, 1, regenerated SOP.
- aso_source1_endofpacket, out, 1, regenerated EOP.
- aso_source1_valid, out, 1, beat valid.
- coe_status_clear, in, 1, synchronous clear of error flag and frame counter.
- coe_status_framing_error, out, 1, sticky framing-error flag.
- coe_status_frame_count, out, 16, completed output frames, wraps at 65535→0.

## Operation
- Input beat is accepted when asi_sink1_valid & asi_sink1_ready.
- Framing FSM operates on accepted beats, with states WAIT_SOP and IN_PKT. The pixel counter is $clog2(N) bits wide.
- WAIT_SOP:
  - Beat with SOP → forwarded with out-SOP=1; counter=1; go to IN_PKT.
  - Beat without SOP → dropped (consumed, never enters pipeline); error flag set.
- IN_PKT, on each beat:
  - Beat forwarded; counter increments.
  - Beat is the last (counter == N-1) → forwarded with out-EOP=1; go to WAIT_SOP; frame_count increments when that beat leaves the source. If the input EOP is absent on this beat, the error flag is set.
  - Input EOP with counter < N-1 → forwarded with out-EOP=1 (short frame); go to WAIT_SOP; error flag set; frame_count increments.
  - Input SOP while in IN_PKT → error flag set; beat treated as an ordinary pixel (out-SOP=0).
- Datapath:
  - Stage 1 registers the products 77*R, 150*G, 29*B; each product is 16 bits.
  - Stage 2 registers (sum + 128) >> 8. The sum is 16 bits unsigned; the maximum is 65408, so there is no overflow. The result is 0..255 with no saturation needed.
- SOP/EOP tags travel alongside the data in each stage.
- Error flag is sticky until coe_status_clear.
  - coe_status_clear clears flag and frame_count.
  - If coe_status_clear coincides with a new error, the error wins and the flag stays 1.
  - If coe_status_clear coincides with a frame completion, frame_count = 0.

## Timing
- Reset (asynchronous, reaches all registers): state WAIT_SOP; counter 0; stage valids 0.
  - Output values during/after reset: aso_source1_valid=0, data=0, SOP=0, EOP=0, framing_error=0, frame_count=0.
- Global advance = ~aso_source1_valid | aso_source1_ready.
  - asi_sink1_ready = advance (combinational, no registered path); it is therefore 1 after reset.
  - When advance=0, both stages and the FSM hold. Bubbles are not collapsed.
- Latency: a beat accepted at edge k appears at the source after edge k+2 when no stall occurs. Full throughput is one pixel per clock.
- Source outputs are held stable while aso_source1_valid=1 and aso_source1_ready=0.
- Dropped beats consume their cycle but produce no output; pipeline valid for that slot is 0.
- Reset mid-frame: all in-flight pixels are discarded. After release, the block waits for a fresh SOP; no partial EOP is emitted.

## Test plan
- Use IMG 4x2 (N=8). Send 8 pixels FFFFFF, FF0000, 00FF00, 0000FF, 000000, then 3×808080, with correct SOP/EOP and ready=1. Required outputs, in order: FF, 4D, 95, 1D, 00, 80, 80, 80. SOP on the first, EOP on the eighth, first output 2 cycles after the first accept, error=0, frame_count=1.
- Same frame with aso_source1_ready toggling 1010…. Required: identical data sequence, no loss or duplication, outputs held while stalled, asi_sink1_ready follows the stall.
- Frame with input EOP on pixel 5 (N=8). Required: 5 outputs with EOP on the 5th; error=1; frame_count=1. The next SOP frame passes normally.
- Three beats without SOP before a valid frame. Required: those beats are accepted and dropped, error=1, and the following frame is output intact.
- Frame of 10 beats (SOP first, no EOP until beat 10). Required: 8 outputs with EOP on the 8th; beats 9–10 dropped; error=1. Then pulse coe_status_clear → error=0, frame_count=0.
- Assert reset_n=0 after pixel 3 of a frame. Required: valid=0 immediately (asynchronous). After release, non-SOP beats are dropped; a new SOP frame yields 8 outputs.
